// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC core and its sampler/averager companion.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACC   = 2'd3
    } sar_state_t;

    localparam int DEF_ADC_WIDTH = 8;

endpackage

// File: rtl/sar_avg_acc.sv
// Sample capture, power-of-two accumulator and truncating mean with a one-cycle publish strobe.
module sar_avg_acc
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH = DEF_ADC_WIDTH,
    parameter int AVG_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ADC_WIDTH-1:0] sample,
    input  logic                 add,
    input  logic                 clear,
    output logic                 publish,
    output logic [ADC_WIDTH-1:0] avg
);

    localparam int AW = ADC_WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(2 ** AVG_LOG2);

    logic [ADC_WIDTH-1:0] sample_q;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_sum;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;

    assign acc_sum = acc + AW'(sample_q);
    assign cnt_inc = cnt + CW'(1);
    // The mean is taken from the running sum so it is ready in the ACC cycle itself.
    assign publish = add && (cnt_inc == FULL);
    assign avg     = acc_sum[AW-1:AVG_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            if (load) begin
                sample_q <= sample;
            end
            if (clear || publish) begin
                acc <= '0;
                cnt <= '0;
            end else if (add) begin
                acc <= acc_sum;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/sar_adc_sampler.sv
// Paces SAR conversions, averages 2^AVG_LOG2 results and offers the mean on a
// valid/ready port, flagging conversion timeouts and results lost to backpressure.
module sar_adc_sampler
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH = DEF_ADC_WIDTH,
    parameter int AVG_LOG2  = 2,
    parameter int RATE_W    = 16,
    parameter int TIMEOUT   = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [RATE_W-1:0]    rate_div,
    input  logic                 clr_err,
    output logic                 adc_start,
    input  logic                 adc_eoc,
    input  logic                 adc_den,
    input  logic [ADC_WIDTH-1:0] adc_dout,
    output logic [ADC_WIDTH-1:0] avg_data,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic                 busy,
    output sar_state_t           fsm_state
);

    // avg_valid/avg_data form a valid/ready source: a word transfers on any cycle
    // where avg_valid && avg_ready; avg_valid never drops without a transfer, and
    // a publish while the word is still unaccepted overwrites it and sets overrun.

    localparam int TW = $clog2(TIMEOUT + 1);

    sar_state_t           state;
    sar_state_t           state_nx;
    logic [RATE_W-1:0]    period_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic                 conv_done;
    logic                 tmo_hit;
    logic                 go;
    logic                 acc_clear;
    logic                 publish;
    logic [ADC_WIDTH-1:0] avg_new;

    assign conv_done = (state == WAIT) && adc_eoc && adc_den;
    assign tmo_hit   = (state == WAIT) && !conv_done && (tmo_cnt == TW'(TIMEOUT));
    assign go        = (state == IDLE) && enable &&
                       ((rate_div <= RATE_W'(1)) || (period_cnt >= rate_div - RATE_W'(1)));
    // Partial sums never survive a pause in sampling.
    assign acc_clear = tmo_hit || (conv_done && !enable) || ((state == IDLE) && !enable);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        adc_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (go) state_nx = START;
            START: begin
                adc_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_nx = enable ? ACC : IDLE;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            ACC:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Zeroed as START is entered so the next start lands exactly rate_div cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (go) begin
                period_cnt <= '0;
            end else if (enable && (period_cnt < rate_div)) begin
                period_cnt <= period_cnt + RATE_W'(1);
            end
            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    sar_avg_acc #(
        .ADC_WIDTH (ADC_WIDTH),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (conv_done),
        .sample  (adc_dout),
        .add     (state == ACC),
        .clear   (acc_clear),
        .publish (publish),
        .avg     (avg_new)
    );

    // Set events win over a coincident clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_data    <= '0;
            avg_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (publish) begin
                avg_data  <= avg_new;
                avg_valid <= 1'b1;
            end else if (avg_ready) begin
                avg_valid <= 1'b0;
            end
            if (publish && avg_valid && !avg_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
